pipe_trace_buffer: RTL and testbench

PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

---
 rtl/pipe_trace_buffer.sv | 175 +++++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - multi-channel pipeline trace buffer with pre/post trigger capture
// Optional TRACE_STAMP_EN stores a 16-bit cycle stamp per entry and adds port rd_stamp.
module pipe_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 5,
  parameter int DEPTH  = 32
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_CH*DATA_W-1:0]                   ch_data,
  input  logic                                       arm,
  input  logic                                       trigger,
  input  logic [$clog2(DEPTH):0]                     post_count,
  input  logic                                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]                   rd_idx,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  output logic [DATA_W-1:0]                          rd_data,
  output logic                                       rd_valid,
`ifdef TRACE_STAMP_EN
  output logic [15:0]                                rd_stamp,
`endif
  output logic [1:0]                                 state,
  output logic [$clog2(DEPTH):0]                     fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef TRACE_STAMP_EN
  localparam int WW = NUM_CH*DATA_W + 16;
`else
  localparam int WW = NUM_CH*DATA_W;
`endif
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [CW:0] NUM_CH_V = (CW+1)'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [AW:0]     rem_q, rem_d;
  logic [AW:0]     post_eff;
  logic            we;
  logic [WW-1:0]   wdata;
  logic [WW-1:0]   mem [DEPTH];

  logic [AW-1:0]   oldest;
  logic [AW-1:0]   rd_addr;
  logic [WW-1:0]   rd_word;
  logic [DATA_W-1:0] rd_sel;
  logic            rd_ok;

  assign state = state_q;
  assign fill  = fill_q;

  // post_count of 0 means "trigger sample only"; larger than DEPTH cannot be held anyway
  always_comb begin
    post_eff = post_count;
    if (post_count == '0)
      post_eff = (AW+1)'(1);
    else if (post_count > DEPTH_V)
      post_eff = DEPTH_V;
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    we      = 1'b0;
    if (arm) begin
      state_d = S_PRE;
      wptr_d  = '0;
      fill_d  = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_PRE: begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (fill_q != DEPTH_V)
            fill_d = fill_q + 1'b1;
          if (trigger) begin
            rem_d   = post_eff - 1'b1;
            state_d = (post_eff == (AW+1)'(1)) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (fill_q != DEPTH_V)
            fill_d = fill_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (AW+1)'(1))
            state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
    end
  end

`ifdef TRACE_STAMP_EN
  logic [15:0] stamp_q;

  always_ff @(posedge clk) begin
    if (reset)
      stamp_q <= '0;
    else
      stamp_q <= stamp_q + 16'd1;
  end

  assign wdata = {stamp_q, ch_data};
`else
  assign wdata = ch_data;
`endif

  // Trace storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (we && !reset)
      mem[wptr_q] <= wdata;
  end

  assign oldest  = (fill_q == DEPTH_V) ? wptr_q : '0;
  assign rd_addr = oldest + rd_idx;
  assign rd_word = mem[rd_addr];
  assign rd_ok   = rd_en && (state_q == S_DONE) && ({1'b0, rd_idx} < fill_q)
                   && ({1'b0, rd_ch} < NUM_CH_V);

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_ch == CW'(k))
        rd_sel = rd_word[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_ok;
      rd_data  <= rd_ok ? rd_sel : '0;
    end
  end

`ifdef TRACE_STAMP_EN
  always_ff @(posedge clk) begin
    if (reset)
      rd_stamp <= '0;
    else
      rd_stamp <= rd_ok ? rd_word[WW-1 -: 16] : 16'd0;
  end
`endif

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - directed and randomized check of pipe_trace_buffer against a queue model
module tb_pipe_trace_buffer;
  localparam int DATA_W = 16;
  localparam int NUM_CH = 5;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;
  localparam int CW     = 3;
  localparam int W      = NUM_CH*DATA_W;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  ch_data;
  logic          arm;
  logic          trigger;
  logic [AW:0]   post_count;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] rd_ch;
  logic [DATA_W-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    state;
  logic [AW:0]   fill;
`ifdef TRACE_STAMP_EN
  logic [15:0]   rd_stamp;
`endif

  always #5 clk = ~clk;

  pipe_trace_buffer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_data    (ch_data),
    .arm        (arm),
    .trigger    (trigger),
    .post_count (post_count),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
`ifdef TRACE_STAMP_EN
    .rd_stamp   (rd_stamp),
`endif
    .state      (state),
    .fill       (fill)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the trace is a queue of samples holding at most DEPTH entries, oldest first
  int           mst;
  int           mrem;
  logic [W-1:0] mq[$];
  logic [15:0]  sq[$];
  logic [15:0]  mcnt;
  logic         exp_valid;
  logic [15:0]  exp_data;
  logic [15:0]  exp_stamp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic push_sample();
    mq.push_back(ch_data);
    sq.push_back(mcnt);
    if (mq.size() > DEPTH) begin
      void'(mq.pop_front());
      void'(sq.pop_front());
    end
  endtask

  task automatic step();
    int c;
    int i;
    int eff;
    logic [W-1:0] w;
    c = int'(rd_ch);
    i = int'(rd_idx);
    exp_valid = rd_en && (mst == 3) && (i < mq.size()) && (c < NUM_CH);
    exp_data  = '0;
    exp_stamp = '0;
    if (exp_valid) begin
      w = mq[i];
      exp_data  = w[c*DATA_W +: DATA_W];
      exp_stamp = sq[i];
    end
    if (reset) begin
      mst = 0; mrem = 0; mq.delete(); sq.delete();
      exp_valid = 1'b0; exp_data = '0; exp_stamp = '0;
      mcnt = '0;
    end else begin
      if (arm) begin
        mst = 1; mrem = 0; mq.delete(); sq.delete();
      end else if (mst == 1) begin
        push_sample();
        if (trigger) begin
          eff = int'(post_count);
          if (eff == 0) eff = 1;
          if (eff > DEPTH) eff = DEPTH;
          mrem = eff - 1;
          mst = (eff == 1) ? 3 : 2;
        end
      end else if (mst == 2) begin
        push_sample();
        mrem--;
        if (mrem == 0) mst = 3;
      end
      mcnt = mcnt + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(mst));
    chk({tag, ".fill"}, 32'(fill), 32'(mq.size()));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_valid));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_data));
`ifdef TRACE_STAMP_EN
    chk({tag, ".rd_stamp"}, 32'(rd_stamp), 32'(exp_stamp));
`endif
  endtask

  task automatic read(input int idx, input int ch);
    rd_en = 1'b1; rd_idx = AW'(idx); rd_ch = CW'(ch);
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; trigger = 1'b0; post_count = '0;
    rd_en = 1'b0; rd_idx = '0; rd_ch = '0; ch_data = '0;
    mst = 0; mrem = 0; mcnt = '0;

    // reset
    step(); step();
    reset = 1'b0;
    check_all("reset");
    chk("reset.state_const", 32'(state), 0);

    // short capture: trigger on 3rd PRE cycle, post_count 4
    arm = 1'b1; step(); arm = 1'b0;
    chk("arm.state", 32'(state), 1);
    chk("arm.fill", 32'(fill), 0);
    for (int n = 1; n <= 6; n++) begin
      ch_data = rand_data(); ch_data[15:0] = 16'(n);
      trigger = (n == 3); post_count = 6'd4;
      step();
      check_all("short.cap");
    end
    trigger = 1'b0;
    chk("short.done", 32'(state), 3);
    chk("short.fill", 32'(fill), 6);
    for (int i = 0; i < 6; i++) begin
      read(i, 0);
      chk("short.rd_valid", 32'(rd_valid), 1);
      chk("short.rd_data", 32'(rd_data), 32'(i + 1));
      check_all("short.rd");
    end
    step();
    check_all("short.idle_rd");

    // wrap: 40 PRE cycles then trigger with post_count 8
    arm = 1'b1; step(); arm = 1'b0;
    for (int n = 1; n <= 48; n++) begin
      ch_data = rand_data(); ch_data[15:0] = 16'(n);
      trigger = (n == 41); post_count = 6'd8;
      step();
    end
    trigger = 1'b0;
    chk("wrap.done", 32'(state), 3);
    chk("wrap.fill", 32'(fill), 32);
    read(0, 0);
    chk("wrap.idx0", 32'(rd_data), 17);
    check_all("wrap.idx0m");
    read(31, 0);
    chk("wrap.idx31", 32'(rd_data), 48);
    check_all("wrap.idx31m");
    read(10, 4);
    check_all("wrap.ch4");

    // post_count 0 on first PRE cycle
    arm = 1'b1; step(); arm = 1'b0;
    ch_data = rand_data(); trigger = 1'b1; post_count = 6'd0;
    step();
    trigger = 1'b0;
    chk("pc0.state", 32'(state), 3);
    chk("pc0.fill", 32'(fill), 1);
    read(0, 2);
    check_all("pc0.rd");

    // arm beats trigger; reads outside DONE rejected
    arm = 1'b1; step(); arm = 1'b0;
    for (int n = 0; n < 3; n++) begin ch_data = rand_data(); step(); end
    arm = 1'b1; trigger = 1'b1; post_count = 6'd1;
    step();
    arm = 1'b0; trigger = 1'b0;
    chk("armtrig.state", 32'(state), 1);
    chk("armtrig.fill", 32'(fill), 0);
    read(0, 0);
    chk("prerd.valid", 32'(rd_valid), 0);
    chk("prerd.data", 32'(rd_data), 0);
    check_all("prerd");

    // reset during POST
    arm = 1'b1; step(); arm = 1'b0;
    ch_data = rand_data(); trigger = 1'b1; post_count = 6'd10; step(); trigger = 1'b0;
    step(); step();
    chk("post.state", 32'(state), 2);
    reset = 1'b1; rd_en = 1'b1; step(); reset = 1'b0; rd_en = 1'b0;
    chk("rstpost.state", 32'(state), 0);
    chk("rstpost.fill", 32'(fill), 0);
    chk("rstpost.rd_valid", 32'(rd_valid), 0);
    check_all("rstpost");

    // out-of-range reads in DONE
    arm = 1'b1; step(); arm = 1'b0;
    for (int n = 0; n < 5; n++) begin
      ch_data = rand_data(); trigger = (n == 3); post_count = 6'd2; step();
    end
    trigger = 1'b0;
    chk("oor.fill", 32'(fill), 5);
    read(5, 0);
    chk("oor.idx_valid", 32'(rd_valid), 0);
    chk("oor.idx_data", 32'(rd_data), 0);
    read(4, 5);
    chk("oor.ch_valid", 32'(rd_valid), 0);
    chk("oor.ch_data", 32'(rd_data), 0);
    read(4, 7);
    check_all("oor.ch7");
    read(4, 4);
    chk("oor.ok_valid", 32'(rd_valid), 1);
    check_all("oor.ok");

    // post_count above DEPTH clamps
    arm = 1'b1; step(); arm = 1'b0;
    ch_data = rand_data(); trigger = 1'b1; post_count = 6'd63; step(); trigger = 1'b0;
    for (int n = 0; n < 31; n++) begin ch_data = rand_data(); trigger = n[0]; step(); end
    trigger = 1'b0;
    chk("clamp.state", 32'(state), 3);
    chk("clamp.fill", 32'(fill), 32);
    step();
    chk("clamp.hold", 32'(state), 3);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      arm        = ($urandom_range(0, 59) == 0);
      trigger    = ($urandom_range(0, 29) == 0);
      post_count = 6'($urandom_range(0, 63));
      rd_en      = $urandom_range(0, 1) == 1;
      rd_idx     = AW'($urandom_range(0, DEPTH - 1));
      rd_ch      = CW'($urandom_range(0, 7));
      ch_data    = rand_data();
      step();
      check_all("rand");
    end
    reset = 1'b0; arm = 1'b0; trigger = 1'b0; rd_en = 1'b0;

`ifdef TRACE_STAMP_EN
    reset = 1'b1; step(); reset = 1'b0;
    for (int n = 0; n < 9; n++) step();
    arm = 1'b1; step(); arm = 1'b0;
    trigger = 1'b1; post_count = 6'd1; step(); trigger = 1'b0;
    read(0, 0);
    chk("stamp.idx0", 32'(rd_stamp), 10);
    check_all("stamp");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
